seg7_scan_mux: RTL and testbench

//  Time-multiplexes the two registered 7-seg digit patterns (tens = msb, units = lsb) onto the Basys3 shared cathode bus.

---
 rtl/seg7_scan_mux_pkg.sv | 46 ++++
 rtl/seg7_scan_mux_scan_timer.sv | 28 ++
 rtl/seg7_scan_mux.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_mux.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants, scan-state encoding and small helpers for the two-digit
// 7-segment scan multiplexer.
package seg7_scan_mux_pkg;

    localparam logic [6:0] SEG_ZERO = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [3:0] AN_U     = 4'b1110;
    localparam logic [3:0] AN_T     = 4'b1101;

    typedef enum logic [1:0] {
        ST_U_ON  = 2'd0,
        ST_U_BLK = 2'd1,
        ST_T_ON  = 2'd2,
        ST_T_BLK = 2'd3
    } scan_state_t;

    // Width that holds 0..len-1 for the longest phase.
    function automatic int unsigned cnt_width(input int unsigned on_cyc,
                                              input int unsigned blank_cyc);
        int unsigned m;
        m = 2;
        if (on_cyc > m)
            m = on_cyc;
        if (blank_cyc > m)
            m = blank_cyc;
        return $clog2(m);
    endfunction

    function automatic scan_state_t advance(input scan_state_t s,
                                            input logic use_blank);
        scan_state_t n;
        case (s)
            ST_U_ON:  n = use_blank ? ST_U_BLK : ST_T_ON;
            ST_U_BLK: n = ST_T_ON;
            ST_T_ON:  n = use_blank ? ST_T_BLK : ST_U_ON;
            default:  n = ST_U_ON;
        endcase
        return n;
    endfunction

    function automatic logic is_blank(input scan_state_t s);
        return (s == ST_U_BLK) || (s == ST_T_BLK);
    endfunction

endpackage

// File: rtl/seg7_scan_mux_scan_timer.sv
// Phase counter: counts 0..len_m1 while running and flags the last cycle of
// the phase so the controller can advance on the same edge the counter wraps.
module scan_timer #(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          run,
    input  logic [CW-1:0] len_m1,
    output logic          tc
);

    logic [CW-1:0] cnt_reg;

    assign tc = run && !clr && (cnt_reg == len_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (run) begin
            cnt_reg <= tc ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Two-digit scan multiplexer for the Basys3 shared cathode bus: alternates
// units and tens with optional dark gaps and optional leading-zero blanking.
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int unsigned ON_CYC    = 100000,
    parameter int unsigned BLANK_CYC = 1000,
    parameter bit          LZ_BLANK  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [6:0] msb,
    input  logic [6:0] lsb,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int unsigned   CW        = cnt_width(ON_CYC, BLANK_CYC);
    localparam logic [CW-1:0] ON_M1     = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] BLK_M1    = (BLANK_CYC == 0) ? '0 : CW'(BLANK_CYC - 1);
    localparam logic          USE_BLANK = (BLANK_CYC != 0);

    scan_state_t     state_reg;
    scan_state_t     state_next;
    logic            active_reg;
    logic            active_next;
    logic [CW-1:0]   len_m1;
    logic            tc;
    logic            timer_clr;
    logic            timer_run;
    logic [1:0]      capture;
    logic [1:0][6:0] digit;
    logic [1:0][6:0] snap_upd;
    logic [6:0]      seg_reg;
    logic [6:0]      seg_next;
    logic [3:0]      an_reg;
    logic [3:0]      an_next;

    // active_reg low means the next enabled edge is a fresh entry into U_ON.
    assign timer_clr = !en || !active_reg;
    assign timer_run = en && active_reg;
    assign len_m1    = is_blank(state_reg) ? BLK_M1 : ON_M1;

    scan_timer #(
        .CW(CW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .run    (timer_run),
        .len_m1 (len_m1),
        .tc     (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_U_ON;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            active_reg <= active_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        active_next = active_reg;
        if (!en) begin
            state_next  = ST_U_ON;
            active_next = 1'b0;
        end else if (!active_reg) begin
            state_next  = ST_U_ON;
            active_next = 1'b1;
        end else if (tc) begin
            state_next = advance(state_reg, USE_BLANK);
        end
    end

    // Digits are sampled only on entry to their lit phase so the cathode
    // bus never changes while an anode is held on.
    assign digit      = {msb, lsb};
    assign capture[0] = (en && !active_reg) || (tc && (state_next == ST_U_ON));
    assign capture[1] = tc && (state_next == ST_T_ON);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_snap
            logic [6:0] snap_reg;
            logic [6:0] snap_next;

            assign snap_next    = capture[gi] ? digit[gi] : snap_reg;
            assign snap_upd[gi] = snap_next;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    snap_reg <= SEG_OFF;
                end else begin
                    snap_reg <= snap_next;
                end
            end
        end
    endgenerate

    always_comb begin
        seg_next = SEG_OFF;
        an_next  = AN_OFF;
        if (en) begin
            case (state_next)
                ST_U_ON: begin
                    an_next  = AN_U;
                    seg_next = snap_upd[0];
                end
                ST_T_ON: begin
                    if (!(LZ_BLANK && (snap_upd[1] == SEG_ZERO))) begin
                        an_next  = AN_T;
                        seg_next = snap_upd[1];
                    end
                end
                default: begin
                    an_next  = AN_OFF;
                    seg_next = SEG_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg <= SEG_OFF;
            an_reg  <= AN_OFF;
        end else begin
            seg_reg <= seg_next;
            an_reg  <= an_next;
        end
    end

    assign seg = seg_reg;
    assign an  = an_reg;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: main build (4/2/LZ), a no-LZ build and a
// no-blank build share the same stimulus.
module tb_seg7_scan_mux;
    import seg7_scan_mux_pkg::*;

    localparam logic [6:0] PAT_A = 7'b1111001;
    localparam logic [6:0] PAT_B = 7'b0100100;
    localparam logic [6:0] PAT_C = 7'b0010010;
    localparam logic [6:0] PAT_D = 7'b0000010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [6:0] msb = PAT_B;
    logic [6:0] lsb = PAT_A;

    logic [6:0] seg_a, seg_b, seg_c;
    logic [3:0] an_a, an_b, an_c;
    logic       dp_a, dp_b, dp_c;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int base = 1;

    always #5 clk = ~clk;

    seg7_scan_mux #(.ON_CYC(4), .BLANK_CYC(2), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .msb(msb), .lsb(lsb),
        .seg(seg_a), .an(an_a), .dp(dp_a));

    seg7_scan_mux #(.ON_CYC(4), .BLANK_CYC(2), .LZ_BLANK(1'b0)) dut_nlz (
        .clk(clk), .rst_n(rst_n), .en(en), .msb(msb), .lsb(lsb),
        .seg(seg_b), .an(an_b), .dp(dp_b));

    seg7_scan_mux #(.ON_CYC(4), .BLANK_CYC(0), .LZ_BLANK(1'b1)) dut_nb (
        .clk(clk), .rst_n(rst_n), .en(en), .msb(msb), .lsb(lsb),
        .seg(seg_c), .an(an_c), .dp(dp_c));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    // 0 = units lit, 1 = dark gap, 2 = tens window (12-cycle period)
    function automatic int phase12(input int kk);
        int m;
        m = (kk - base) % 12;
        if (m < 4) return 0;
        if (m < 6) return 1;
        if (m < 10) return 2;
        return 1;
    endfunction

    function automatic int phase8(input int kk);
        int m;
        m = (kk - base) % 8;
        return (m < 4) ? 0 : 2;
    endfunction

    task automatic check_main(input logic [6:0] u, input logic [6:0] t, input bit with_nb);
        int p;
        logic [3:0] ea;
        logic [6:0] es;
        p = phase12(k);
        ea = AN_OFF;
        es = SEG_OFF;
        if (p == 0) begin
            ea = AN_U;
            es = u;
        end else if (p == 2 && t != SEG_ZERO) begin
            ea = AN_T;
            es = t;
        end
        check("an", 8'(an_a), 8'(ea));
        check("seg", 8'(seg_a), 8'(es));
        check("dp", 8'(dp_a), 8'd1);
        if (with_nb) begin
            if (phase8(k) == 0) begin
                ea = AN_U;
                es = u;
            end else begin
                ea = AN_T;
                es = t;
            end
            check("nb_an", 8'(an_c), 8'(ea));
            check("nb_seg", 8'(seg_c), 8'(es));
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_an"}, 8'(an_a), 8'(AN_OFF));
        check({tag, "_seg"}, 8'(seg_a), 8'(SEG_OFF));
        check({tag, "_dp"}, 8'(dp_a), 8'd1);
        check({tag, "_nlz_an"}, 8'(an_b), 8'(AN_OFF));
        check({tag, "_nb_an"}, 8'(an_c), 8'(AN_OFF));
        check({tag, "_nb_seg"}, 8'(seg_c), 8'(SEG_OFF));
    endtask

    // Every cycle: at most one anode low; seg moves only while dark or with an.
    logic [6:0] prev_seg = SEG_OFF;
    logic [3:0] prev_an = AN_OFF;
    always @(negedge clk) begin
        check("onehot_a", ($countones(~an_a) <= 1) ? 8'd1 : 8'd0, 8'd1);
        check("onehot_nlz", ($countones(~an_b) <= 1) ? 8'd1 : 8'd0, 8'd1);
        check("onehot_nb", ($countones(~an_c) <= 1) ? 8'd1 : 8'd0, 8'd1);
        check("seg_glitch",
              ((seg_a === prev_seg) || (an_a === AN_OFF) || (an_a !== prev_an)) ? 8'd1 : 8'd0,
              8'd1);
        check("dp_nlz_nb", {6'd0, dp_b, dp_c}, 8'b11);
        prev_seg = seg_a;
        prev_an = an_a;
    end

    initial begin
        // Reset held: outputs dark
        repeat (3) begin
            tick();
            check_dark("reset");
        end
        rst_n = 1'b1;
        k = 0;
        base = 1;

        // Basic scan, two full periods
        for (int i = 0; i < 24; i++) begin
            tick();
            check_main(PAT_A, PAT_B, 1'b1);
            $display("cycle %0d: an=%b seg=%b", k, an_a, seg_a);
        end

        // Leading zero on tens
        msb = SEG_ZERO;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_main(PAT_A, SEG_ZERO, 1'b0);
            if (phase12(k) == 2) begin
                check("nlz_an", 8'(an_b), 8'(AN_T));
                check("nlz_seg", 8'(seg_b), 8'(SEG_ZERO));
            end
            $display("cycle %0d: an=%b seg=%b nlz_an=%b nlz_seg=%b", k, an_a, seg_a, an_b, seg_b);
        end

        // Mid-phase lsb change is deferred to the next units entry
        msb = PAT_B;
        lsb = PAT_C;
        for (int i = 0; i < 19; i++) begin
            tick();
            check_main((k < 49) ? PAT_C : PAT_D, PAT_B, 1'b0);
            $display("cycle %0d: an=%b seg=%b", k, an_a, seg_a);
            if (k == 37)
                lsb = PAT_D;
        end

        // Enable dropped during tens window, raised 5 cycles later
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_dark("en_low");
            $display("cycle %0d: en=0 an=%b seg=%b", k, an_a, seg_a);
        end
        en = 1'b1;
        base = k + 1;
        for (int i = 0; i < 14; i++) begin
            tick();
            check_main(PAT_D, PAT_B, 1'b1);
            $display("cycle %0d: an=%b seg=%b", k, an_a, seg_a);
        end

        // Asynchronous reset pulse between edges, mid units phase
        #2;
        rst_n = 1'b0;
        #1;
        check_dark("async_rst");
        $display("cycle %0d: async reset an=%b seg=%b dp=%b", k, an_a, seg_a, dp_a);
        #1;
        rst_n = 1'b1;
        base = k + 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_main(PAT_D, PAT_B, 1'b1);
            $display("cycle %0d: an=%b seg=%b", k, an_a, seg_a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
